countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 15 +
 rtl/countdown_timer_ms_ticker.sv | 29 ++
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the millisecond countdown timer: FSM state encoding
// and default timing/width constants.
package countdown_pkg;

    localparam int unsigned CLK_PER_MS_DEF = 50000;
    localparam int unsigned WIDTH_DEF      = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_PAUSED  = 2'd2;
    localparam state_t ST_EXPIRED = 2'd3;

endpackage

// File: rtl/countdown_timer_ms_ticker.sv
// Millisecond prescaler: counts enabled clock cycles and strobes tick on the
// last cycle of each millisecond, holding its count while disabled.
module ms_ticker #(
    parameter int unsigned CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the FSM sees the tick in the same cycle the count wraps.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable millisecond countdown timer with pause, cancel and expiry
// reporting; the prescaler lives in ms_ticker, all sequencing lives here.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             pause,
    input  logic             cancel,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             expired,
    output logic             expired_pulse
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] remaining_nxt;
    logic             pulse_nxt;
    logic             apply_tick;
    logic             load_acc;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;

    assign load_ready = ((state == ST_IDLE) || (state == ST_EXPIRED)) && !cancel;
    assign load_acc   = load_valid && load_ready;

    // PAUSED with pause released counts too, so a pause costs exactly its
    // own length and no extra resume cycle.
    assign tick_en  = ((state == ST_RUN) || (state == ST_PAUSED)) && !pause && !cancel;
    assign tick_clr = cancel || load_acc;

    ms_ticker #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ticker (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (tick_clr),
        .tick(tick)
    );

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pulse_nxt     = 1'b0;
        apply_tick    = 1'b0;
        if (cancel) begin
            state_nxt     = ST_IDLE;
            remaining_nxt = '0;
        end else begin
            case (state)
                ST_IDLE, ST_EXPIRED: begin
                    if (load_acc) begin
                        remaining_nxt = load_value;
                        if (load_value == '0) begin
                            state_nxt = ST_EXPIRED;
                            pulse_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else begin
                        apply_tick = tick;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_nxt  = ST_RUN;
                        apply_tick = tick;
                    end
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    remaining_nxt = '0;
                end
            endcase
            // Saturating decrement: the last millisecond lands on zero and expires.
            if (apply_tick) begin
                if (remaining <= WIDTH'(1)) begin
                    remaining_nxt = '0;
                    state_nxt     = ST_EXPIRED;
                    pulse_nxt     = 1'b1;
                end else begin
                    remaining_nxt = remaining - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            busy          <= 1'b0;
            expired       <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            busy          <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSED);
            expired       <= (state_nxt == ST_EXPIRED);
            expired_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with a 4-cycle millisecond: each stimulus
// cycle queues its hand-derived expectation, a monitor pops and compares.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_value = '0;
    logic        load_ready;
    logic        pause = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] remaining;
    logic        busy;
    logic        expired;
    logic        expired_pulse;

    typedef struct {
        bit          lr_chk;
        bit          lr;
        logic [31:0] rem;
        bit          busy;
        bit          exp;
        bit          pulse;
        int          scn;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   scn_id = 0;

    countdown_timer #(
        .CLK_PER_MS(4),
        .WIDTH     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_value   (load_value),
        .load_ready   (load_ready),
        .pause        (pause),
        .cancel       (cancel),
        .remaining    (remaining),
        .busy         (busy),
        .expired      (expired),
        .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want,
                       input int scn, input int idx);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s scn%0d cyc%0d: got %0d expected %0d", nm, scn, idx, act, want);
        end
    endtask

    // One stimulus cycle: inputs held across the next rising edge; lr is the
    // expected load_ready during the cycle, the rest are outputs after the edge.
    task automatic cyc(input bit lv, input logic [31:0] val, input bit p, input bit c,
                       input bit r, input bit lr_chk, input bit lr, input logic [31:0] rem,
                       input bit b, input bit e, input bit pl, input int idx);
        exp_t x;
        @(negedge clk);
        load_valid = lv;
        load_value = val;
        pause      = p;
        cancel     = c;
        rst        = r;
        x.lr_chk = lr_chk;
        x.lr     = lr;
        x.rem    = rem;
        x.busy   = b;
        x.exp    = e;
        x.pulse  = pl;
        x.scn    = scn_id;
        x.idx    = idx;
        q.push_back(x);
    endtask

    task automatic idle(input int idx, input bit lr, input logic [31:0] rem,
                        input bit b, input bit e, input bit pl);
        cyc(0, 0, 0, 0, 0, 1, lr, rem, b, e, pl, idx);
    endtask

    task automatic do_cancel();
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, -1);
    endtask

    initial begin : monitor
        exp_t x;
        logic lr_s;
        forever begin
            @(negedge clk);
            #1;
            lr_s = load_ready;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.lr_chk) chk("load_ready", {31'd0, lr_s}, {31'd0, x.lr}, x.scn, x.idx);
                chk("remaining", remaining, x.rem, x.scn, x.idx);
                chk("busy", {31'd0, busy}, {31'd0, x.busy}, x.scn, x.idx);
                chk("expired", {31'd0, expired}, {31'd0, x.exp}, x.scn, x.idx);
                chk("expired_pulse", {31'd0, expired_pulse}, {31'd0, x.pulse}, x.scn, x.idx);
            end
        end
    end

    initial begin : stimulus
        int rem;
        // Reset
        scn_id = 0;
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        idle(2, 1, 0, 0, 0, 0);

        // Load 3, plain countdown
        scn_id = 1;
        cyc(1, 3, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
        for (int j = 1; j <= 14; j++) begin
            rem = (j < 12) ? 3 - j / 4 : 0;
            idle(j, j >= 13, rem, j < 12, j >= 12, j == 12);
        end
        do_cancel();

        // Load 0 goes straight to EXPIRED; pause ignored there
        scn_id = 2;
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 3; j++) cyc(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, j);
        do_cancel();

        // Load 5, pause across edges 6..13
        scn_id = 3;
        cyc(1, 5, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0);
        for (int j = 1; j <= 30; j++) begin
            rem = (j < 4) ? 5 : (j < 16) ? 4 : (j < 20) ? 3 : (j < 24) ? 2 : (j < 28) ? 1 : 0;
            cyc(0, 0, (j >= 6 && j <= 13), 0, 0, 1, j >= 29, rem, j < 28, j >= 28, j == 28, j);
        end
        do_cancel();

        // Cancel beats a simultaneous load
        scn_id = 4;
        cyc(1, 5, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0);
        for (int j = 1; j <= 5; j++) idle(j, 0, (j < 4) ? 5 : 4, 1, 0, 0);
        cyc(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 6);
        idle(7, 1, 0, 0, 0, 0);
        idle(8, 1, 0, 0, 0, 0);

        // Reload from EXPIRED; load_valid during RUN ignored
        scn_id = 5;
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, -2);
        cyc(1, 2, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        for (int j = 1; j <= 10; j++) begin
            rem = (j < 4) ? 2 : (j < 8) ? 1 : 0;
            cyc(j <= 3, 7, 0, 0, 0, 1, j >= 9, rem, j < 8, j >= 8, j == 8, j);
        end
        do_cancel();

        // Reset mid-countdown, reset blocks a load, prescaler restarts from 0
        scn_id = 6;
        cyc(1, 5, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0);
        for (int j = 1; j <= 6; j++) idle(j, 0, (j < 4) ? 5 : 4, 1, 0, 0);
        cyc(1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 7);
        idle(8, 1, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 1, 1, 1, 0, 0, 0, 0, 9);
        cyc(1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 10);
        for (int j = 11; j <= 13; j++) idle(j, 0, 1, 1, 0, 0);
        idle(14, 0, 0, 0, 1, 1);
        idle(15, 1, 0, 0, 1, 0);

        @(negedge clk);
        load_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0, 99, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
